// File: rtl/uart_system_top.sv
// uart_system_top
//   Single-clock UART command processor. Serial bytes arriving on ser_data_in
//   are framed (start, 8 data LSB first, even parity, stop), decoded as
//   commands, and used to access a 16x8 register file and a 16-bit-result ALU.
//   Read data and ALU results are returned on ser_data_out with the same
//   frame format.
//
//   Commands: AA addr data  -> write register
//             BB addr       -> read register, 1 response byte
//             CC a b op     -> reg0=a, reg1=b, then ALU op, 2 response bytes
//             DD op         -> ALU op on reg0/reg1, 2 response bytes (lo, hi)
//
// Ports
//   ref_clk      in   sole clock, rising edge
//   reset        in   asynchronous, active-high
//   ser_data_in  in   serial receive line (idle high, asynchronous)
//   ser_data_out out  serial transmit line (idle high)
//   par_error    out  one-cycle pulse on a frame with bad parity
//   frame_error  out  one-cycle pulse on a frame whose stop bit is 0
//   tx_busy      out  high while a response frame is on the line
module uart_system_top #(
  parameter int DATA_WIDTH               = 8,
  parameter int REGISTER_FILE_DEPTH      = 16,
  parameter int SYNCHRONIZER_STAGE_COUNT = 2,
  parameter int CLKS_PER_BIT             = 16
) (
  input  logic ref_clk,
  input  logic reset,
  input  logic ser_data_in,
  output logic ser_data_out,
  output logic par_error,
  output logic frame_error,
  output logic tx_busy
);

  localparam int DW = DATA_WIDTH;
  localparam int AW = $clog2(REGISTER_FILE_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] BIT_MID  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] GAP_LEN  = CW'(CLKS_PER_BIT);

  function automatic logic [2*DW-1:0] alu_op(input logic [3:0] op,
                                              input logic [DW-1:0] a,
                                              input logic [DW-1:0] b);
    logic [2*DW-1:0] ea;
    logic [2*DW-1:0] eb;
    ea = {{DW{1'b0}}, a};
    eb = {{DW{1'b0}}, b};
    case (op)
      4'h0:    alu_op = ea + eb;
      4'h1:    alu_op = ea - eb;
      4'h2:    alu_op = ea * eb;
      4'h3:    alu_op = (b == '0) ? '0 : ea / eb;
      4'h4:    alu_op = ea & eb;
      4'h5:    alu_op = ea | eb;
      4'h6:    alu_op = {{DW{1'b0}}, ~(a & b)};
      4'h7:    alu_op = {{DW{1'b0}}, ~(a | b)};
      4'h8:    alu_op = ea ^ eb;
      4'h9:    alu_op = {{DW{1'b0}}, ~(a ^ b)};
      4'hA:    alu_op = (a == b) ? (2*DW)'(1) : '0;
      4'hB:    alu_op = (a > b)  ? (2*DW)'(2) : '0;
      4'hC:    alu_op = (a < b)  ? (2*DW)'(3) : '0;
      4'hD:    alu_op = ea >> 1;
      4'hE:    alu_op = ea << 1;
      default: alu_op = '0;
    endcase
  endfunction

  // ---------------- input synchronizer ----------------
  logic [SYNCHRONIZER_STAGE_COUNT-1:0] sync_q;
  logic                                rx_in;

  always_ff @(posedge ref_clk or posedge reset) begin
    if (reset) sync_q <= '1;
    else       sync_q <= (sync_q << 1) | SYNCHRONIZER_STAGE_COUNT'(ser_data_in);
  end

  assign rx_in = sync_q[SYNCHRONIZER_STAGE_COUNT-1];

  // ---------------- receiver ----------------
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_BITS} rx_state_t;
  rx_state_t      rx_state, rx_state_nxt;
  logic [CW-1:0]  rx_cnt;
  logic [3:0]     rx_idx;
  logic [DW-1:0]  rx_data;
  logic           rx_par_bit;
  logic           rx_prev;
  logic           rx_bit_end;
  logic           rx_valid, rx_par_bad, rx_stop_bad, rx_err;

  assign rx_bit_end = (rx_cnt == BIT_LAST);
  assign rx_err     = rx_par_bad | rx_stop_bad;

  always_comb begin
    rx_state_nxt = rx_state;
    rx_valid     = 1'b0;
    rx_par_bad   = 1'b0;
    rx_stop_bad  = 1'b0;
    case (rx_state)
      RX_IDLE:  if (rx_prev && !rx_in) rx_state_nxt = RX_START;
      // a start bit that is high again at mid-bit was a glitch
      RX_START: if (rx_cnt == BIT_MID) rx_state_nxt = rx_in ? RX_IDLE : RX_BITS;
      RX_BITS: begin
        if (rx_bit_end && rx_idx == 4'(DW + 1)) begin
          rx_state_nxt = RX_IDLE;
          rx_stop_bad  = !rx_in;
          rx_par_bad   = ((^rx_data) != rx_par_bit);
          rx_valid     = rx_in && ((^rx_data) == rx_par_bit);
        end
      end
      default:  rx_state_nxt = RX_IDLE;
    endcase
  end

  always_ff @(posedge ref_clk or posedge reset) begin
    if (reset) begin
      rx_state    <= RX_IDLE;
      rx_cnt      <= '0;
      rx_idx      <= '0;
      rx_prev     <= 1'b1;
      par_error   <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      rx_state    <= rx_state_nxt;
      rx_prev     <= rx_in;
      par_error   <= rx_par_bad;
      frame_error <= rx_stop_bad;
      if (rx_state != rx_state_nxt || rx_bit_end) rx_cnt <= '0;
      else if (rx_state != RX_IDLE)               rx_cnt <= rx_cnt + CW'(1);
      if (rx_state == RX_START)                rx_idx <= '0;
      else if (rx_state == RX_BITS && rx_bit_end) rx_idx <= rx_idx + 4'(1);
    end
  end

  always_ff @(posedge ref_clk) begin
    if (rx_state == RX_BITS && rx_bit_end) begin
      if (rx_idx < 4'(DW))       rx_data    <= {rx_in, rx_data[DW-1:1]};
      else if (rx_idx == 4'(DW)) rx_par_bit <= rx_in;
    end
  end

  // ---------------- transmitter ----------------
  typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;
  tx_state_t      tx_state, tx_state_nxt;
  logic [DW+2:0]  tx_frame;
  logic [CW-1:0]  tx_cnt;
  logic [3:0]     tx_idx;
  logic           tx_start, tx_done;
  logic [DW-1:0]  tx_data;

  assign tx_done = (tx_state == TX_SEND) && (tx_cnt == BIT_LAST) && (tx_idx == 4'(DW + 2));

  always_comb begin
    tx_state_nxt = tx_state;
    case (tx_state)
      TX_IDLE: if (tx_start) tx_state_nxt = TX_SEND;
      TX_SEND: if (tx_done)  tx_state_nxt = TX_IDLE;
      default: tx_state_nxt = TX_IDLE;
    endcase
  end

  always_ff @(posedge ref_clk or posedge reset) begin
    if (reset) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_idx   <= '0;
    end else begin
      tx_state <= tx_state_nxt;
      if (tx_state == TX_IDLE || tx_cnt == BIT_LAST) tx_cnt <= '0;
      else                                           tx_cnt <= tx_cnt + CW'(1);
      if (tx_state == TX_IDLE)     tx_idx <= '0;
      else if (tx_cnt == BIT_LAST) tx_idx <= tx_idx + 4'(1);
    end
  end

  always_ff @(posedge ref_clk) begin
    if (tx_state == TX_IDLE) begin
      if (tx_start) tx_frame <= {1'b1, ^tx_data, tx_data, 1'b0};
    end else if (tx_cnt == BIT_LAST) begin
      tx_frame <= {1'b1, tx_frame[DW+2:1]};
    end
  end

  // line is forced idle by state alone, so reset releases it immediately
  assign tx_busy      = (tx_state == TX_SEND);
  assign ser_data_out = !tx_busy || tx_frame[0];

  // ---------------- command controller ----------------
  typedef enum logic [2:0] {IDLE, WR_ADDR, WR_DATA, RD_ADDR, OPA, OPB, FUNC, RESP} ctl_state_t;
  ctl_state_t      ctl_state, ctl_state_nxt;
  logic [DW-1:0]   regs [REGISTER_FILE_DEPTH];
  logic [AW-1:0]   wr_addr;
  logic [DW-1:0]   resp_lo, resp_hi;
  logic            resp_two;
  logic            resp_idx;
  logic            resp_sending;
  logic [CW-1:0]   gap_cnt;
  logic [2*DW-1:0] alu_res;

  assign alu_res = alu_op(rx_data[3:0], regs[0], regs[1]);
  assign tx_data = resp_idx ? resp_hi : resp_lo;

  always_comb begin
    ctl_state_nxt = ctl_state;
    tx_start      = 1'b0;
    // a bad frame abandons a partly received command; responses run to completion
    if (ctl_state != RESP && rx_err) begin
      ctl_state_nxt = IDLE;
    end else begin
      case (ctl_state)
        IDLE: begin
          if (rx_valid) begin
            case (rx_data)
              DW'(8'hAA): ctl_state_nxt = WR_ADDR;
              DW'(8'hBB): ctl_state_nxt = RD_ADDR;
              DW'(8'hCC): ctl_state_nxt = OPA;
              DW'(8'hDD): ctl_state_nxt = FUNC;
              default:    ctl_state_nxt = IDLE;
            endcase
          end
        end
        WR_ADDR: if (rx_valid) ctl_state_nxt = WR_DATA;
        WR_DATA: if (rx_valid) ctl_state_nxt = IDLE;
        RD_ADDR: if (rx_valid) ctl_state_nxt = RESP;
        OPA:     if (rx_valid) ctl_state_nxt = OPB;
        OPB:     if (rx_valid) ctl_state_nxt = FUNC;
        FUNC:    if (rx_valid) ctl_state_nxt = RESP;
        RESP: begin
          // gap_cnt holds off the second byte so the line idles a full bit
          tx_start = !resp_sending && (gap_cnt == '0);
          if (tx_done && (resp_idx == resp_two)) ctl_state_nxt = IDLE;
        end
        default: ctl_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge ref_clk or posedge reset) begin
    if (reset) begin
      ctl_state    <= IDLE;
      resp_sending <= 1'b0;
      resp_idx     <= 1'b0;
      gap_cnt      <= '0;
      for (int i = 0; i < REGISTER_FILE_DEPTH; i++) regs[i] <= '0;
    end else begin
      ctl_state <= ctl_state_nxt;
      if (ctl_state == RESP) begin
        if (tx_start) begin
          resp_sending <= 1'b1;
        end else if (tx_done) begin
          resp_sending <= 1'b0;
          resp_idx     <= ~resp_idx;
          gap_cnt      <= GAP_LEN;
        end else if (!resp_sending && gap_cnt != '0) begin
          gap_cnt <= gap_cnt - CW'(1);
        end
      end else begin
        resp_sending <= 1'b0;
        resp_idx     <= 1'b0;
        gap_cnt      <= '0;
      end
      if (rx_valid) begin
        case (ctl_state)
          WR_DATA: regs[wr_addr] <= rx_data;
          OPA:     regs[0]       <= rx_data;
          OPB:     regs[1]       <= rx_data;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge ref_clk) begin
    if (rx_valid) begin
      case (ctl_state)
        WR_ADDR: wr_addr <= rx_data[AW-1:0];
        RD_ADDR: begin
          resp_lo  <= regs[rx_data[AW-1:0]];
          resp_two <= 1'b0;
        end
        FUNC: begin
          {resp_hi, resp_lo} <= alu_res;
          resp_two           <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_system_top.sv
// tb_uart_system_top
//   Directed bench for uart_system_top: drives serial command frames, decodes
//   response frames from ser_data_out and compares them with hand-computed
//   values.
module tb_uart_system_top;

  localparam int CPB = 16;

  logic ref_clk = 1'b0;
  logic reset;
  logic ser_data_in;
  logic ser_data_out;
  logic par_error;
  logic frame_error;
  logic tx_busy;

  int checks = 0;
  int errors = 0;

  logic [11:0] rxq[$];  // {busy at start, start bit, stop, parity, data}
  int epoch    = 0;
  int par_cnt  = 0;
  int frm_cnt  = 0;
  int low_run  = 0;
  int last_gap = 0;

  uart_system_top #(
    .DATA_WIDTH(8),
    .REGISTER_FILE_DEPTH(16),
    .SYNCHRONIZER_STAGE_COUNT(2),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .ref_clk(ref_clk),
    .reset(reset),
    .ser_data_in(ser_data_in),
    .ser_data_out(ser_data_out),
    .par_error(par_error),
    .frame_error(frame_error),
    .tx_busy(tx_busy)
  );

  always #5 ref_clk = ~ref_clk;

  always @(posedge reset) epoch++;

  always @(negedge ref_clk) begin
    if (par_error)   par_cnt++;
    if (frame_error) frm_cnt++;
    if (tx_busy) begin
      if (low_run != 0) last_gap = low_run;
      low_run = 0;
    end else begin
      low_run++;
    end
  end

  // serial decoder for the transmit line
  initial begin
    forever begin : frame_rx
      int          ep;
      logic [11:0] w;
      @(negedge ser_data_out);
      ep = epoch;
      repeat (CPB / 2) @(negedge ref_clk);
      w[11] = tx_busy;
      w[10] = ser_data_out;
      for (int i = 0; i < 10; i++) begin
        repeat (CPB) @(negedge ref_clk);
        w[i] = ser_data_out;
      end
      if (ep == epoch && !reset) rxq.push_back(w);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic bad_par, input logic bad_stop);
    logic [10:0] f;
    f = {~bad_stop, (^d) ^ bad_par, d, 1'b0};
    @(posedge ref_clk); #1;
    for (int i = 0; i < 11; i++) begin
      ser_data_in = f[i];
      repeat (CPB) @(posedge ref_clk);
      #1;
    end
    ser_data_in = 1'b1;
    repeat (bad_stop ? CPB : 2) @(posedge ref_clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d);
    send_frame(d, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge ref_clk);
    #1;
  endtask

  task automatic expect_byte(input string tag, input logic [7:0] exp);
    int          t = 0;
    logic [11:0] w;
    while (rxq.size() == 0 && t < 4000) begin
      @(negedge ref_clk);
      t++;
    end
    chk({tag, "_arrived"}, 32'(rxq.size() != 0), 32'd1);
    if (rxq.size() != 0) begin
      w = rxq.pop_front();
      chk({tag, "_data"}, 32'(w[7:0]), 32'(exp));
      chk({tag, "_frame"}, 32'(w[11:8]), 32'({1'b1, 1'b0, 1'b1, ^exp}));
    end
  endtask

  task automatic read_check(input string tag, input logic [7:0] addr, input logic [7:0] exp);
    send_byte(8'hBB);
    send_byte(addr);
    expect_byte(tag, exp);
  endtask

  task automatic alu_check(input string tag, input logic [15:0] exp);
    expect_byte({tag, "_lo"}, exp[7:0]);
    expect_byte({tag, "_hi"}, exp[15:8]);
    chk({tag, "_gap"}, 32'(last_gap >= CPB), 32'd1);
  endtask

  initial begin
    int t;
    reset       = 1'b1;
    ser_data_in = 1'b1;
    repeat (3) @(posedge ref_clk);
    #1;
    chk("rst_ser_out", 32'(ser_data_out), 32'd1);
    chk("rst_tx_busy", 32'(tx_busy), 32'd0);
    chk("rst_par_err", 32'(par_error), 32'd0);
    chk("rst_frm_err", 32'(frame_error), 32'd0);
    reset = 1'b0;
    idle(5);

    // basic write then read
    send_byte(8'hAA); send_byte(8'h05); send_byte(8'h3C);
    idle(300);
    chk("wr_silent", 32'(rxq.size()), 32'd0);
    read_check("rd5", 8'h05, 8'h3C);
    chk("no_par_err", 32'(par_cnt), 32'd0);
    chk("no_frm_err", 32'(frm_cnt), 32'd0);

    // full register file
    for (int a = 0; a < 16; a++) begin
      send_byte(8'hAA); send_byte(8'(a)); send_byte(8'(8'h10 + a));
    end
    for (int a = 0; a < 16; a++) read_check("rd_all", 8'(a), 8'(8'h10 + a));
    read_check("rd_alias", 8'h25, 8'h15);

    // ALU with operands
    send_byte(8'hCC); send_byte(8'h0A); send_byte(8'h03); send_byte(8'h02);
    alu_check("mul_0a_03", 16'h001E);
    read_check("reg0", 8'h00, 8'h0A);
    read_check("reg1", 8'h01, 8'h03);
    send_byte(8'hCC); send_byte(8'hFF); send_byte(8'hFF); send_byte(8'h02);
    alu_check("mul_ff_ff", 16'hFE01);

    // ALU without operands
    send_byte(8'hDD); send_byte(8'h00);
    alu_check("add_ff_ff", 16'h01FE);
    send_byte(8'hDD); send_byte(8'h03);
    alu_check("div_ff_ff", 16'h0001);
    send_byte(8'hCC); send_byte(8'h05); send_byte(8'h00); send_byte(8'h03);
    alu_check("div_by_0", 16'h0000);
    send_byte(8'hDD); send_byte(8'h0B);
    alu_check("gt_05_00", 16'h0002);
    send_byte(8'hDD); send_byte(8'h0E);
    alu_check("shl_05", 16'h000A);
    send_byte(8'hDD); send_byte(8'h06);
    alu_check("nand_05_00", 16'h00FF);
    send_byte(8'hDD); send_byte(8'h01);
    alu_check("sub_05_00", 16'h0005);

    // bad parity on the command byte: nothing written
    send_frame(8'hAA, 1'b1, 1'b0);
    idle(20);
    chk("par_pulse", 32'(par_cnt), 32'd1);
    send_byte(8'h05); send_byte(8'h77);
    idle(300);
    chk("par_silent", 32'(rxq.size()), 32'd0);
    read_check("no_wr_par", 8'h05, 8'h15);

    // bad stop mid-command aborts the write
    send_byte(8'hAA);
    send_frame(8'h05, 1'b0, 1'b1);
    idle(20);
    chk("frm_pulse", 32'(frm_cnt), 32'd1);
    chk("frm_no_par", 32'(par_cnt), 32'd1);
    send_byte(8'h05); send_byte(8'h77);
    read_check("abort_frm", 8'h05, 8'h15);

    // short low glitch on an idle line
    ser_data_in = 1'b0;
    repeat (CPB / 4) @(posedge ref_clk);
    #1;
    ser_data_in = 1'b1;
    idle(400);
    chk("glitch_par", 32'(par_cnt), 32'd1);
    chk("glitch_frm", 32'(frm_cnt), 32'd1);
    chk("glitch_silent", 32'(rxq.size()), 32'd0);

    // reset in the middle of a response frame
    send_byte(8'hBB); send_byte(8'h05);
    t = 0;
    while (!tx_busy && t < 2000) begin
      @(negedge ref_clk);
      t++;
    end
    chk("busy_seen", 32'(tx_busy), 32'd1);
    repeat (40) @(negedge ref_clk);
    reset = 1'b1;
    #1;
    chk("rst_mid_ser_out", 32'(ser_data_out), 32'd1);
    chk("rst_mid_busy", 32'(tx_busy), 32'd0);
    repeat (3) @(posedge ref_clk);
    #1;
    rxq.delete();
    reset = 1'b0;
    idle(5);
    read_check("post_rst5", 8'h05, 8'h00);
    read_check("post_rst0", 8'h00, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
